// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - Shared state codes, lamp bit positions and lamp decode for the intersection controller.
package tl_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_G = 3'd0,
        ST_MAIN_Y = 3'd1,
        ST_RED_A  = 3'd2,
        ST_SIDE_G = 3'd3,
        ST_SIDE_Y = 3'd4,
        ST_RED_B  = 3'd5,
        ST_WALK   = 3'd6,
        ST_FLASH  = 3'd7
    } tl_state_e;

    localparam int LAMP_MAIN_G = 0;
    localparam int LAMP_MAIN_Y = 1;
    localparam int LAMP_MAIN_R = 2;
    localparam int LAMP_SIDE_G = 3;
    localparam int LAMP_SIDE_Y = 4;
    localparam int LAMP_SIDE_R = 5;
    localparam int LAMP_WALK   = 6;
    localparam int LAMP_W      = 7;

    typedef logic [LAMP_W-1:0] lamp_vec_t;

    // Flash is the only state whose lamps depend on anything but the state itself.
    function automatic lamp_vec_t lamps_of(input tl_state_e s, input logic blink);
        lamp_vec_t v;
        v = '0;
        case (s)
            ST_MAIN_G: begin
                v[LAMP_MAIN_G] = 1'b1;
                v[LAMP_SIDE_R] = 1'b1;
            end
            ST_MAIN_Y: begin
                v[LAMP_MAIN_Y] = 1'b1;
                v[LAMP_SIDE_R] = 1'b1;
            end
            ST_RED_A, ST_RED_B: begin
                v[LAMP_MAIN_R] = 1'b1;
                v[LAMP_SIDE_R] = 1'b1;
            end
            ST_SIDE_G: begin
                v[LAMP_MAIN_R] = 1'b1;
                v[LAMP_SIDE_G] = 1'b1;
            end
            ST_SIDE_Y: begin
                v[LAMP_MAIN_R] = 1'b1;
                v[LAMP_SIDE_Y] = 1'b1;
            end
            ST_WALK: begin
                v[LAMP_MAIN_R] = 1'b1;
                v[LAMP_SIDE_R] = 1'b1;
                v[LAMP_WALK]   = 1'b1;
            end
            ST_FLASH: begin
                v[LAMP_MAIN_Y] = blink;
                v[LAMP_SIDE_R] = blink;
            end
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - Tick-paced phase counter with clear priority and end-of-phase strobe.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    assign done = tick & (cnt == limit);

    // The owner clears on every phase change, so cnt never runs past limit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/intersection_controller.sv
// rtl/intersection_controller.sv - Main/side traffic sequencer with all-red clearance, walk phase and flash mode.
module intersection_controller
    import tl_pkg::*;
#(
    parameter int MAIN_GREEN   = 29,
    parameter int SIDE_GREEN   = 19,
    parameter int YELLOW_TIME  = 4,
    parameter int ALL_RED_TIME = 1,
    parameter int WALK_TIME    = 9,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       flash_en,
    output logic       main_g,
    output logic       main_y,
    output logic       main_r,
    output logic       side_g,
    output logic       side_y,
    output logic       side_r,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);

    tl_state_e        state;
    tl_state_e        state_next;
    logic             ped_pending;
    logic             blink;
    logic             enter_walk;
    logic             timer_clr;
    logic             done;
    logic [CNT_W-1:0] limit;
    lamp_vec_t        lamps;

    always_comb begin
        limit = '0;
        case (state)
            ST_MAIN_G:          limit = CNT_W'(MAIN_GREEN);
            ST_MAIN_Y, ST_SIDE_Y: limit = CNT_W'(YELLOW_TIME);
            ST_RED_A, ST_RED_B: limit = CNT_W'(ALL_RED_TIME);
            ST_SIDE_G:          limit = CNT_W'(SIDE_GREEN);
            ST_WALK:            limit = CNT_W'(WALK_TIME);
            default:            limit = '0;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .clr   (timer_clr),
        .limit (limit),
        .done  (done)
    );

    always_comb begin
        state_next = state;
        if (flash_en) begin
            state_next = ST_FLASH;
        end else if (state == ST_FLASH) begin
            // Leaving flash always passes through a full all-red clearance.
            state_next = ST_RED_B;
        end else if (done) begin
            case (state)
                ST_MAIN_G: state_next = ST_MAIN_Y;
                ST_MAIN_Y: state_next = ST_RED_A;
                ST_RED_A:  state_next = ST_SIDE_G;
                ST_SIDE_G: state_next = ST_SIDE_Y;
                ST_SIDE_Y: state_next = ST_RED_B;
                ST_RED_B:  state_next = ped_pending ? ST_WALK : ST_MAIN_G;
                ST_WALK:   state_next = ST_MAIN_G;
                default:   state_next = ST_MAIN_G;
            endcase
        end
    end

    assign enter_walk = (state == ST_RED_B) && (state_next == ST_WALK);
    // Holding the timer cleared in flash keeps cnt at 0 for the eventual exit.
    assign timer_clr  = (state_next != state) || (state == ST_FLASH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_MAIN_G;
            ped_pending <= 1'b0;
            ped_ack     <= 1'b0;
            blink       <= 1'b0;
        end else begin
            state       <= state_next;
            ped_pending <= (ped_pending & ~enter_walk) | ped_req;
            ped_ack     <= enter_walk;
            if ((state_next == ST_FLASH) && (state != ST_FLASH)) begin
                blink <= 1'b1;
            end else if ((state == ST_FLASH) && tick) begin
                blink <= ~blink;
            end
        end
    end

    assign lamps  = lamps_of(state, blink);
    assign main_g = lamps[LAMP_MAIN_G];
    assign main_y = lamps[LAMP_MAIN_Y];
    assign main_r = lamps[LAMP_MAIN_R];
    assign side_g = lamps[LAMP_SIDE_G];
    assign side_y = lamps[LAMP_SIDE_Y];
    assign side_r = lamps[LAMP_SIDE_R];
    assign walk   = lamps[LAMP_WALK];
    assign phase  = state;

endmodule

// File: tb/tb_intersection_controller.sv
// tb/tb_intersection_controller.sv - Scoreboard bench for intersection_controller against a countdown reference model.
module tb_intersection_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       ped_req = 1'b0;
    logic       flash_en = 1'b0;
    logic       main_g, main_y, main_r, side_g, side_y, side_r, walk, ped_ack;
    logic [2:0] phase;

    intersection_controller dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .ped_req  (ped_req),
        .flash_en (flash_en),
        .main_g   (main_g),
        .main_y   (main_y),
        .main_r   (main_r),
        .side_g   (side_g),
        .side_y   (side_y),
        .side_r   (side_r),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .phase    (phase)
    );

    always #5 clk = ~clk;

    localparam int P_MG = 0, P_MY = 1, P_RA = 2, P_SG = 3, P_SY = 4, P_RB = 5, P_WK = 6, P_FL = 7;

    typedef struct {
        logic [2:0] ph;
        logic [6:0] lamps;
        logic       ack;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   ack_count = 0;
    int   walk_cycles = 0;

    int   m_state = P_MG;
    int   m_rem = 30;
    bit   m_pend = 0;
    bit   m_blink = 0;
    bit   m_ack = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            P_MG:       return 30;
            P_MY, P_SY: return 5;
            P_RA, P_RB: return 2;
            P_SG:       return 20;
            P_WK:       return 10;
            default:    return 1;
        endcase
    endfunction

    // {walk, side_r, side_y, side_g, main_r, main_y, main_g}
    function automatic logic [6:0] lamp_exp(input int s, input bit b);
        case (s)
            P_MG:       return 7'b0100001;
            P_MY:       return 7'b0100010;
            P_RA, P_RB: return 7'b0100100;
            P_SG:       return 7'b0001100;
            P_SY:       return 7'b0010100;
            P_WK:       return 7'b1100100;
            default:    return b ? 7'b0100010 : 7'b0000000;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit t, input bit q, input bit f);
        bit new_pend;
        int nxt;
        if (r) begin
            m_state = P_MG; m_rem = dur(P_MG); m_pend = 0; m_blink = 0; m_ack = 0;
            return;
        end
        new_pend = m_pend | q;
        m_ack = 0;
        if (f) begin
            if (m_state != P_FL) m_blink = 1;
            else if (t) m_blink = ~m_blink;
            m_state = P_FL;
        end else if (m_state == P_FL) begin
            if (t) m_blink = ~m_blink;
            m_state = P_RB;
            m_rem = dur(P_RB);
        end else if (t) begin
            m_rem--;
            if (m_rem == 0) begin
                case (m_state)
                    P_RB:    nxt = m_pend ? P_WK : P_MG;
                    P_WK:    nxt = P_MG;
                    default: nxt = m_state + 1;
                endcase
                if (nxt == P_WK) begin
                    new_pend = q;
                    m_ack = 1;
                end
                m_state = nxt;
                m_rem = dur(nxt);
            end
        end
        m_pend = new_pend;
    endtask

    task automatic cycle(input bit r, input bit t, input bit q, input bit f);
        exp_t e;
        rst = r; tick = t; ped_req = q; flash_en = f;
        model_step(r, t, q, f);
        e.ph = 3'(m_state);
        e.lamps = lamp_exp(m_state, m_blink);
        e.ack = m_ack;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("phase", 32'(phase), 32'(e.ph));
        check("lamps", 32'({walk, side_r, side_y, side_g, main_r, main_y, main_g}), 32'(e.lamps));
        check("ped_ack", 32'(ped_ack), 32'(e.ack));
        if (ped_ack) ack_count++;
        if (walk) walk_cycles++;
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (phase != 3'(target) && n < budget) begin
            cycle(0, 1, 0, 0);
            n++;
        end
        if (phase != 3'(target)) check("timeout_phase", 32'(phase), 32'(target));
    endtask

    task automatic do_reset();
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
    endtask

    int trans_q[$];
    int exp_trans[6] = '{30, 35, 37, 57, 62, 64};

    initial begin
        logic [2:0] last;
        int n;
        bit fl;

        // Reset state and the plain 64-clock cycle
        do_reset();
        check("reset_phase", 32'(phase), 32'd0);
        check("reset_pending", 32'(dut.ped_pending), 32'd0);
        last = phase;
        for (int i = 1; i <= 64; i++) begin
            cycle(0, 1, 0, 0);
            if (phase != last) trans_q.push_back(i);
            last = phase;
        end
        check("trans_count", 32'(trans_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < trans_q.size(); k++) check("trans_cycle", 32'(trans_q[k]), 32'(exp_trans[k]));

        // Request during SIDE_G gives one 10-cycle walk
        do_reset();
        run_until(P_SG, 100);
        ack_count = 0; walk_cycles = 0;
        cycle(0, 1, 1, 0);
        for (int i = 0; i < 90; i++) cycle(0, 1, 0, 0);
        check("walk_len", 32'(walk_cycles), 32'd10);
        check("walk_acks", 32'(ack_count), 32'd1);

        // Request on the WALK entry edge is served again next round
        do_reset();
        run_until(P_SG, 100);
        cycle(0, 1, 1, 0);
        n = 0;
        while (!(m_state == P_RB && m_rem == 1) && n < 200) begin
            cycle(0, 1, 0, 0);
            n++;
        end
        ack_count = 0;
        cycle(0, 1, 1, 0);
        check("entry_phase", 32'(phase), 32'(P_WK));
        for (int i = 0; i < 150; i++) cycle(0, 1, 0, 0);
        check("entry_acks", 32'(ack_count), 32'd2);

        // Tick every 4th clock stretches MAIN_G to 120 clocks
        do_reset();
        n = 0;
        for (int i = 0; i < 200 && phase == 3'(P_MG); i++) begin
            cycle(0, (i % 4) == 3, 0, 0);
            n = i + 1;
        end
        check("main_g_len", 32'(n), 32'd120);

        // Flash from MAIN_Y with a request pending, then exit through RED_B into WALK
        do_reset();
        cycle(0, 1, 1, 0);
        run_until(P_MY, 100);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 1);
        check("flash_entry", 32'(phase), 32'(P_FL));
        for (int i = 0; i < 11; i++) cycle(0, (i % 2) == 0, 0, 1);
        ack_count = 0;
        cycle(0, 1, 0, 0);
        check("flash_exit", 32'(phase), 32'(P_RB));
        for (int i = 0; i < 20; i++) cycle(0, 1, 0, 0);
        check("flash_walk", 32'(ack_count), 32'd1);

        // Flash with nothing pending returns to MAIN_G
        run_until(P_SG, 100);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 1);
        ack_count = 0;
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        check("flash_nowalk_phase", 32'(phase), 32'(P_MG));
        check("flash_nowalk_acks", 32'(ack_count), 32'd0);

        // Reset mid-SIDE_G drops a pending request
        run_until(P_SG, 100);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        check("rst_phase", 32'(phase), 32'(P_MG));
        check("rst_pending", 32'(dut.ped_pending), 32'd0);
        ack_count = 0;
        for (int i = 0; i < 80; i++) cycle(0, 1, 0, 0);
        check("rst_no_walk", 32'(ack_count), 32'd0);

        // Random traffic against the model
        fl = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) fl = ~fl;
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 19) == 0, fl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
